cluster_issue_scheduler: RTL and testbench

Parametrised successor of the 4-PE cluster controller. Fetches a window of NUM_PE sequential instructions and detects RAW/WAW hazards and control-flow instructions within the window. It issues the longest hazard-free in-order prefix to the PEs, waits for every issued PE to complete, then advances the PC or follows a PE-reported redirect. It sits between the instruction memory and the PE array of one cluster.

---
 rtl/cluster_issue_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_cluster_issue_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cluster_issue_scheduler.sv
// Cluster issue scheduler: fetches an NUM_PE-wide window, issues its longest hazard-free
// in-order prefix and waits for every issued PE. Optional perf counters: SCHED_PERF_CNT_EN.
module cluster_issue_scheduler #(
    parameter int unsigned     NUM_PE   = 4,
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic                   imem_req,
    output logic [NUM_PE*XLEN-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [NUM_PE*XLEN-1:0] imem_rdata,
    output logic [NUM_PE-1:0]      pe_issue_valid,
    output logic [NUM_PE*XLEN-1:0] pe_pc,
    output logic [NUM_PE*XLEN-1:0] pe_instr,
    input  logic [NUM_PE-1:0]      pe_done,
    input  logic [NUM_PE-1:0]      pe_redirect_valid,
    input  logic [NUM_PE*XLEN-1:0] pe_redirect_pc,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_windows,
`endif
    output logic                   busy
);
    localparam int KW = $clog2(NUM_PE + 1);
    localparam int LW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [XLEN-1:0]        base_q, base_d;
    logic [KW-1:0]          k_q, k_d;
    logic [NUM_PE-1:0]      mask_q, mask_d;
    logic                   redir_valid_q, redir_valid_d;
    logic [LW-1:0]          redir_lane_q, redir_lane_d;
    logic [XLEN-1:0]        redir_pc_q, redir_pc_d;
    logic [NUM_PE*XLEN-1:0] pc_q, pc_d;
    logic [NUM_PE*XLEN-1:0] instr_q, instr_d;

    logic [6:0]        opc [NUM_PE];
    logic [4:0]        rd  [NUM_PE];
    logic [4:0]        rs1 [NUM_PE];
    logic [4:0]        rs2 [NUM_PE];
    logic [NUM_PE-1:0] use_rs1, use_rs2, wr, is_cf;
    logic [KW-1:0]     issue_cnt;
    logic [NUM_PE-1:0] issue_mask, done_eff;
    logic              hit_valid;
    logic [LW-1:0]     hit_lane;
    logic [XLEN-1:0]   hit_pc;

    // Per-lane decode: only fields the format actually uses take part in hazard checks.
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            opc[i]     = instr_q[i*XLEN +: 7];
            rd[i]      = instr_q[i*XLEN+7 +: 5];
            rs1[i]     = instr_q[i*XLEN+15 +: 5];
            rs2[i]     = instr_q[i*XLEN+20 +: 5];
            // NOTE: every comb output gets a default before the case, so no latch is inferred.
            wr[i]      = 1'b0;
            use_rs1[i] = 1'b0;
            use_rs2[i] = 1'b0;
            case (opc[i])
                7'b0110011:                         begin wr[i] = 1'b1; use_rs1[i] = 1'b1; use_rs2[i] = 1'b1; end
                7'b0000011, 7'b0010011, 7'b1100111: begin wr[i] = 1'b1; use_rs1[i] = 1'b1; end
                7'b0110111, 7'b0010111, 7'b1101111: wr[i] = 1'b1;
                7'b0100011, 7'b1100011:             begin use_rs1[i] = 1'b1; use_rs2[i] = 1'b1; end
                default: ;
            endcase
            wr[i]    = wr[i] && (rd[i] != 5'd0);
            is_cf[i] = (opc[i] == 7'b1100011) || (opc[i] == 7'b1101111) || (opc[i] == 7'b1100111);
        end
    end

    // A hazard at lane j cuts before j; a control-flow lane j cuts after j.
    always_comb begin
        logic cut, hz;
        cut       = 1'b0;
        hz        = 1'b0;
        issue_cnt = KW'(NUM_PE);
        for (int j = 0; j < NUM_PE; j++) begin
            hz = 1'b0;
            for (int i = 0; i < j; i++) begin
                if (wr[i] && ((use_rs1[j] && rs1[j] == rd[i]) ||
                              (use_rs2[j] && rs2[j] == rd[i]) ||
                              (wr[j] && rd[j] == rd[i])))
                    hz = 1'b1;
            end
            if (!cut && hz) begin
                issue_cnt = KW'(j);
                cut       = 1'b1;
            end else if (!cut && is_cf[j]) begin
                issue_cnt = KW'(j + 1);
                cut       = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PE; i++) issue_mask[i] = (KW'(i) < issue_cnt);
    end

    // Lowest-indexed completing lane carrying a redirect this cycle (ISSUE-cycle dones included).
    always_comb begin
        done_eff  = (state_q == S_ISSUE) ? (pe_done & issue_mask) :
                    (state_q == S_WAIT)  ? (pe_done & mask_q)     : '0;
        hit_valid = 1'b0;
        hit_lane  = '0;
        hit_pc    = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (done_eff[i] && pe_redirect_valid[i]) begin
                hit_valid = 1'b1;
                hit_lane  = LW'(i);
                hit_pc    = pe_redirect_pc[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        k_d           = k_q;
        mask_d        = mask_q;
        redir_valid_d = redir_valid_q;
        redir_lane_d  = redir_lane_q;
        redir_pc_d    = redir_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_ISSUE;
                    pc_d    = imem_addr;
                    instr_d = imem_rdata;
                end
            end
            S_ISSUE: begin
                state_d       = S_WAIT;
                k_d           = issue_cnt;
                mask_d        = issue_mask & ~pe_done;
                redir_valid_d = hit_valid;
                redir_lane_d  = hit_lane;
                redir_pc_d    = hit_pc;
            end
            default: begin
                mask_d = mask_q & ~pe_done;
                if (hit_valid && (!redir_valid_q || hit_lane < redir_lane_q)) begin
                    redir_valid_d = 1'b1;
                    redir_lane_d  = hit_lane;
                    redir_pc_d    = hit_pc;
                end
                if (mask_d == '0) begin
                    base_d  = redir_valid_d ? redir_pc_d : base_q + XLEN'(k_q) * XLEN'(PC_STEP);
                    state_d = enable ? S_FETCH : S_IDLE;
                end
            end
        endcase
    end

    // NOTE: window/PC registers are reset too, because they drive pe_pc/pe_instr directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            base_q        <= RESET_PC;
            k_q           <= '0;
            mask_q        <= '0;
            redir_valid_q <= 1'b0;
            redir_lane_q  <= '0;
            redir_pc_q    <= '0;
            pc_q          <= '0;
            instr_q       <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q       <= state_d;
            base_q        <= base_d;
            k_q           <= k_d;
            mask_q        <= mask_d;
            redir_valid_q <= redir_valid_d;
            redir_lane_q  <= redir_lane_d;
            redir_pc_q    <= redir_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_windows_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued_q  <= '0;
            perf_windows_q <= '0;
        end else if (state_q == S_ISSUE) begin
            perf_issued_q  <= perf_issued_q + 32'(issue_cnt);
            perf_windows_q <= perf_windows_q + 32'd1;
        end
    end
    assign perf_issued  = perf_issued_q;
    assign perf_windows = perf_windows_q;
`endif

    always_comb begin
        for (int i = 0; i < NUM_PE; i++) imem_addr[i*XLEN +: XLEN] = base_q + XLEN'(i) * XLEN'(PC_STEP);
    end

    assign imem_req       = (state_q == S_FETCH);
    assign pe_issue_valid = (state_q == S_ISSUE) ? issue_mask : '0;
    assign pe_pc          = pc_q;
    assign pe_instr       = instr_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_cluster_issue_scheduler.sv
// Directed bench for cluster_issue_scheduler (NUM_PE=4, XLEN=32, PC_STEP=1, RESET_PC=0)
// with an issue scoreboard; perf counters are checked when SCHED_PERF_CNT_EN is defined.
module tb_cluster_issue_scheduler;
    localparam int NUM_PE = 4;
    localparam int XLEN   = 32;

    logic                   clk = 1'b0;
    logic                   reset_n, enable, imem_req, imem_ack, busy;
    logic [NUM_PE*XLEN-1:0] imem_addr, imem_rdata, pe_pc, pe_instr, pe_redirect_pc;
    logic [NUM_PE-1:0]      pe_issue_valid, pe_done, pe_redirect_valid;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]            perf_issued, perf_windows;
`endif

    typedef struct {
        logic [NUM_PE-1:0]      valid;
        logic [NUM_PE*XLEN-1:0] pc;
        logic [NUM_PE*XLEN-1:0] instr;
    } issue_t;

    issue_t sb[$];
    int     checks = 0;
    int     errors = 0;

    localparam logic [127:0] W_INDEP = {32'h00300293, 32'h00200213, 32'h00100193, 32'h00500093};
    localparam logic [127:0] W_RAW   = {32'h00200213, 32'h00100193, 32'h00108133, 32'h00500093};
    localparam logic [127:0] W_RR    = {32'h00200293, 32'h00100213, 32'h001081B3, 32'h00108133};
    localparam logic [127:0] W_BR    = {32'h00300193, 32'h00200113, 32'h00000463, 32'h00100093};

    cluster_issue_scheduler #(.NUM_PE(NUM_PE), .XLEN(XLEN), .PC_STEP(1), .RESET_PC('0)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .pe_issue_valid    (pe_issue_valid),
        .pe_pc             (pe_pc),
        .pe_instr          (pe_instr),
        .pe_done           (pe_done),
        .pe_redirect_valid (pe_redirect_valid),
        .pe_redirect_pc    (pe_redirect_pc),
`ifdef SCHED_PERF_CNT_EN
        .perf_issued       (perf_issued),
        .perf_windows      (perf_windows),
`endif
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] addrs(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Waits for the fetch, answers it, pushes the expected issue and checks it in the ISSUE cycle.
    task automatic serve_fetch(input logic [127:0] win, input logic [31:0] base, input logic [3:0] kmask);
        issue_t e;
        int     n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, addrs(base));
        e.valid = kmask;
        e.pc    = addrs(base);
        e.instr = win;
        sb.push_back(e);
        imem_rdata = win;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("req_drop", imem_req, 0);
        check("issue_seen", (pe_issue_valid != '0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("issue_valid", pe_issue_valid, e.valid);
            for (int i = 0; i < NUM_PE; i++) begin
                if (e.valid[i]) begin
                    check($sformatf("pe_pc%0d", i), pe_pc[i*XLEN +: XLEN], e.pc[i*XLEN +: XLEN]);
                    check($sformatf("pe_instr%0d", i), pe_instr[i*XLEN +: XLEN], e.instr[i*XLEN +: XLEN]);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        pe_done = '0; pe_redirect_valid = '0; pe_redirect_pc = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_req", imem_req, 0);
        check("rst_issue", pe_issue_valid, 0);
        check("rst_pc", pe_pc, 0);
        check("rst_instr", pe_instr, 0);
        check("rst_addr", imem_addr, addrs(0));
        reset_n = 1'b1;
        tick();
        check("idle_no_enable", busy, 0);
        enable = 1'b1;

        // Independent window: full issue, next base 4.
        serve_fetch(W_INDEP, 32'd0, 4'b1111);
        check("busy_issue", busy, 1);
        tick(); pe_done = 4'b1111; tick(); pe_done = '0;

        // RAW on lane 1: only lane 0 issues; done on unissued lanes is ignored.
        serve_fetch(W_RAW, 32'd4, 4'b0001);
        tick(); pe_done = 4'b1110; tick(); pe_done = '0;
        check("unissued_done_ignored", imem_req, 0);
        check("busy_wait", busy, 1);
        pe_done = 4'b0001; tick(); pe_done = '0;

        // Read-read sharing, refetch from pc 5; out-of-order completion.
        serve_fetch(W_RR, 32'd5, 4'b1111);
        tick(); pe_done = 4'b0100; tick(); pe_done = '0;
        check("ooo_wait1", imem_req, 0);
        pe_done = 4'b0011; tick(); pe_done = '0;
        check("ooo_wait2", imem_req, 0);
        check("pc_stable", pe_pc, addrs(5));
        pe_done = 4'b1000; tick(); pe_done = '0;
        check("ooo_fetch", imem_req, 1);

        // Branch in lane 1: lanes 0..1 issue; lane 0 completes in the ISSUE cycle; lane 1 redirects to 10.
        serve_fetch(W_BR, 32'd9, 4'b0011);
        pe_done = 4'b0001;
        tick(); pe_done = '0;
        check("zero_lat_wait", imem_req, 0);
        pe_done = 4'b0010; pe_redirect_valid = 4'b0010;
        pe_redirect_pc = {32'd77, 32'd66, 32'd10, 32'd55};
        tick(); pe_done = '0; pe_redirect_valid = '0; pe_redirect_pc = '0;

        // Redirect target window, then reset in the middle of WAIT.
        serve_fetch(W_INDEP, 32'd10, 4'b1111);
        tick(); pe_done = 4'b0011; tick(); pe_done = '0;
`ifdef SCHED_PERF_CNT_EN
        check("perf_issued", perf_issued, 15);
        check("perf_windows", perf_windows, 5);
`endif
        reset_n = 1'b0; enable = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_req", imem_req, 0);
        check("midrst_pc", pe_pc, 0);
        check("midrst_instr", pe_instr, 0);
        check("midrst_addr", imem_addr, addrs(0));
        tick();
        reset_n = 1'b1;
        pe_done = 4'b1100; imem_ack = 1'b1;
        tick();
        pe_done = '0; imem_ack = 1'b0;
        check("late_busy", busy, 0);
        check("late_issue", pe_issue_valid, 0);
`ifdef SCHED_PERF_CNT_EN
        check("perf_issued_rst", perf_issued, 0);
        check("perf_windows_rst", perf_windows, 0);
`endif

        // Restart at RESET_PC; dropping enable returns to IDLE after completion.
        enable = 1'b1;
        serve_fetch(W_INDEP, 32'd0, 4'b1111);
        tick(); enable = 1'b0; pe_done = 4'b1111; tick(); pe_done = '0;
        check("idle_busy", busy, 0);
        check("idle_req", imem_req, 0);
        check("idle_addr", imem_addr, addrs(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
